// File: rtl/switch_pkg.sv
// switch_pkg: definitions shared by the byte switch and its endpoints.
//   - PORT_N/S/E/W : 2-bit port codes carried in data[DEST_MSB:DEST_LSB]
//   - DEST_MSB/LSB : position of the route field inside a byte
//   - tx_state_t   : state encoding of the endpoint TX burst FSM
package switch_pkg;

  localparam logic [1:0] PORT_N = 2'b00;
  localparam logic [1:0] PORT_S = 2'b01;
  localparam logic [1:0] PORT_E = 2'b10;
  localparam logic [1:0] PORT_W = 2'b11;

  localparam int DEST_MSB = 7;
  localparam int DEST_LSB = 6;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_FIN  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/switch_node_tx.sv
// switch_node_tx: burst generator for the switch endpoint.
// Sends i_len bytes {dest, seq} with seq starting at i_seed and counting
// modulo 64, over a valid/ready master interface.
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_start, i_dest, i_len,   burst request (accepted only when idle)
//   i_seed
//   o_busy                    high while bytes are being offered
//   o_done                    one-cycle pulse after the burst ends
//   o_tx_valid, i_tx_ready,   byte stream towards the switch
//   o_tx_data
module switch_node_tx
  import switch_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_dest,
  input  logic [LEN_W-1:0] i_len,
  input  logic [5:0]       i_seed,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic [7:0]       o_tx_data
);

  tx_state_t        state_reg, state_next;
  logic [1:0]       dest_reg, dest_next;
  logic [LEN_W-1:0] remaining_reg, remaining_next;
  logic [5:0]       seq_reg, seq_next;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg     <= TX_IDLE;
      dest_reg      <= '0;
      remaining_reg <= '0;
      seq_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      dest_reg      <= dest_next;
      remaining_reg <= remaining_next;
      seq_reg       <= seq_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    dest_next      = dest_reg;
    remaining_next = remaining_reg;
    seq_next       = seq_reg;
    case (state_reg)
      TX_IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            state_next     = TX_SEND;
            dest_next      = i_dest;
            remaining_next = i_len;
            seq_next       = i_seed;
          end else begin
            // Empty burst: still report completion, but offer nothing.
            state_next = TX_FIN;
          end
        end
      end
      TX_SEND: begin
        if (i_tx_ready) begin
          remaining_next = remaining_reg - LEN_W'(1);
          seq_next       = seq_reg + 6'd1;  // natural 6-bit wrap 63 -> 0
          if (remaining_reg == LEN_W'(1)) begin
            state_next = TX_FIN;
          end
        end
      end
      TX_FIN:  state_next = TX_IDLE;
      default: state_next = TX_IDLE;
    endcase
  end

  // All outputs decode registered state only, so valid never follows ready
  // combinationally and data only moves after an accepted transfer.
  assign o_tx_valid = (state_reg == TX_SEND);
  assign o_busy     = (state_reg == TX_SEND);
  assign o_done     = (state_reg == TX_FIN);
  assign o_tx_data  = {dest_reg, seq_reg};

endmodule

// File: rtl/switch_node.sv
// switch_node: traffic source/sink endpoint for one port of the byte switch.
// TX: burst generator (switch_node_tx). RX: byte sink keeping a saturating
// count, a mod-256 checksum and a sticky route-error flag.
// Optional build macro: SWITCH_NODE_THROTTLE_EN -- RX ready is asserted only
// one cycle in THROTTLE_PERIOD to exercise switch back-pressure; without it
// RX ready is high from the first cycle after reset.
// Ports:
//   i_clk, i_rst_n                       clock, synchronous active-low reset
//   i_start, i_dest, i_len, i_seed       burst request
//   o_busy, o_done                       burst status
//   o_tx_valid, i_tx_ready, o_tx_data    TX stream into the switch
//   i_rx_valid, o_rx_ready, i_rx_data    RX stream from the switch
//   i_clr                                clear RX statistics
//   o_rx_count, o_rx_sum, o_rx_err       RX statistics
module switch_node
  import switch_pkg::*;
#(
  parameter logic [1:0] NODE_ID         = PORT_N,
  parameter int         LEN_W           = 8,
  parameter int         CNT_W           = 16,
  parameter int         THROTTLE_PERIOD = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_dest,
  input  logic [LEN_W-1:0] i_len,
  input  logic [5:0]       i_seed,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic [7:0]       o_tx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready,
  input  logic [7:0]       i_rx_data,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_rx_count,
  output logic [7:0]       o_rx_sum,
  output logic             o_rx_err
);

  // A period below 2 would leave the throttled sink permanently ready.
  if (THROTTLE_PERIOD < 2) begin : g_period_check
    $error("switch_node: THROTTLE_PERIOD must be >= 2");
  end

  switch_node_tx #(.LEN_W(LEN_W)) u_tx (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_dest     (i_dest),
    .i_len      (i_len),
    .i_seed     (i_seed),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_tx_data  (o_tx_data)
  );

  // ---------------- RX ready ----------------
`ifdef SWITCH_NODE_THROTTLE_EN
  localparam int THR_W = (THROTTLE_PERIOD > 1) ? $clog2(THROTTLE_PERIOD) : 1;
  localparam logic [THR_W-1:0] THR_LAST = THR_W'(THROTTLE_PERIOD - 1);

  logic [THR_W-1:0] thr_cnt_reg, thr_cnt_next;

  always_comb begin
    thr_cnt_next = (thr_cnt_reg == THR_LAST) ? '0 : thr_cnt_reg + THR_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) thr_cnt_reg <= '0;
    else          thr_cnt_reg <= thr_cnt_next;
  end

  assign o_rx_ready = (thr_cnt_reg == THR_LAST);
`else
  logic rx_ready_reg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) rx_ready_reg <= 1'b0;
    else          rx_ready_reg <= 1'b1;
  end

  assign o_rx_ready = rx_ready_reg;
`endif

  // ---------------- RX statistics ----------------
  logic             rx_fire, rx_bad;
  logic [CNT_W-1:0] count_reg, count_next, count_base;
  logic [7:0]       sum_reg, sum_next, sum_base;
  logic             err_reg, err_next, err_base;

  assign rx_fire = i_rx_valid && o_rx_ready;
  assign rx_bad  = (i_rx_data[DEST_MSB:DEST_LSB] != NODE_ID);

  always_comb begin
    // Clear first, then accumulate, so a clear coinciding with a transfer
    // leaves exactly that byte in the statistics.
    count_base = i_clr ? '0 : count_reg;
    sum_base   = i_clr ? '0 : sum_reg;
    err_base   = i_clr ? 1'b0 : err_reg;
    count_next = count_base;
    sum_next   = sum_base;
    err_next   = err_base;
    if (rx_fire) begin
      if (count_base != '1) count_next = count_base + CNT_W'(1);
      sum_next = sum_base + i_rx_data;
      err_next = err_base | rx_bad;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count_reg <= '0;
      sum_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      sum_reg   <= sum_next;
      err_reg   <= err_next;
    end
  end

  assign o_rx_count = count_reg;
  assign o_rx_sum   = sum_reg;
  assign o_rx_err   = err_reg;

endmodule
